spart_key_rx: RTL and testbench
===============================

Name: spart_key_rx

Overview:
- UART receive front end for the CPU's SPART key interface.
- Deserialises 8N1 bytes from the host serial line and maps recognised ASCII control characters to one-hot 5-bit key codes.
- Buffers key codes in a small FIFO and delivers one code per CPU poll request as a one-cycle SPART_we pulse with SPART_keys.
- Sits directly upstream of the cpu SPART_we/SPART_keys inputs.

Parameters:
- BAUD_DIV, 27, clk cycles per 16x oversample tick (50 MHz / (115200*16)).
- FIFO_DEPTH, 4, key FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx  in  1  serial input, idle high, asynchronous to clk
- key_req  in  1  CPU poll request, one-cycle pulse issued by the CPU key-read instruction
- SPART_we  out  1  key-valid strobe to CPU, one cycle
- SPART_keys  out  5  one-hot key code, valid when SPART_we=1
- frame_err  out  1  one-cycle pulse when a stop bit samples 0
- ovf  out  1  one-cycle pulse when a valid key is dropped because the FIFO is full
- fifo_empty  out  1  high when no key is buffered

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; tick counter, bit counter and FIFO pointers clear.
  - SPART_we=0, SPART_keys=5'h00, frame_err=0, ovf=0, fifo_empty=1.
  - Synchroniser flops are set to 1 (line idle).
  - Reset mid-frame discards the partial byte.
- Synchroniser: rx passes through a 2-flop synchroniser; all logic uses the synchronised signal.
- Tick generator: free-running counter 0..BAUD_DIV-1 that pulses tick at wrap.
- RX FSM (advances on tick only, except where noted):
  - IDLE: on falling edge of synchronised rx (checked every clk, not only on tick), clear the oversample count and go to START.
  - START: after 8 ticks, sample rx. If rx=0, go to DATA. If rx=1, treat as a glitch and return to IDLE.
  - DATA: sample every 16 ticks, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx. If rx=1, the byte is complete; go to IDLE. If rx=0, pulse frame_err, discard the byte and go to IDLE. The line must return high before the next falling edge is accepted.
- Key map (case-insensitive letters):
  - 'W'/'w' -> 5'h01, 'S'/'s' -> 5'h02, 'A'/'a' -> 5'h04, 'D'/'d' -> 5'h08, 0x20 (space) -> 5'h10.
  - All other bytes are dropped silently.
- FIFO push: one cycle after STOP completes with a mapped byte.
  - If full and no pop in the same cycle, drop the key and pulse ovf.
- Poll:
  - key_req with FIFO non-empty: next cycle SPART_we=1, SPART_keys=head, and head is popped. Latency is 1 clk.
  - key_req with FIFO empty: next cycle SPART_we=0, SPART_keys=5'h00. There is no bypass of a same-cycle push.
  - SPART_keys returns to 5'h00 whenever SPART_we=0.
- Simultaneous push and pop:
  - When full: pop takes priority, push succeeds, count unchanged, no ovf.
  - When empty: the push lands, the pop returns empty.
- Back-to-back key_req on consecutive cycles is legal; each request pops at most one entry.
- Pointers: log2(FIFO_DEPTH)+1 bits; wrap naturally. Full = MSBs differ and remaining bits equal.
- All outputs are registered.

Decomposition:
- Package spart_pkg:
  - key code constants KEY_UP=5'h01, KEY_DOWN=5'h02, KEY_LEFT=5'h04, KEY_RIGHT=5'h08, KEY_FIRE=5'h10.
  - RX state enum rx_state_t {IDLE, START, DATA, STOP}.
  - ASCII-to-key mapping function.
- Sub-module spart_uart_rx: synchroniser, tick generator and RX FSM. Outputs byte_valid (one-cycle pulse), byte[7:0] and frame_err.
- Top level holds the key map, FIFO and poll logic.

Test Plan:
- Send 'w' (0x77) at BAUD_DIV=27, then pulse key_req -> SPART_we=1 with SPART_keys=5'h01 exactly 1 clk after key_req; fifo_empty=1 afterward.
- Send 'D', 'x', ' ', then issue 3 key_reqs -> responses 5'h08, 5'h10, then SPART_we=0 with keys 5'h00 ('x' dropped).
- Send 5 valid keys with no polls, FIFO_DEPTH=4 -> ovf pulses once on the 5th key; 4 polls return the first four codes in order.
- Byte 'a' with stop bit forced 0 -> frame_err pulses once, no push, fifo_empty stays 1. Next a valid 's' -> 5'h02.
- rx low glitch of 4 ticks -> START rejects it and returns to IDLE; no byte, no error.
- Assert rst during DATA bit 4 of 'w', release, then send 'a' -> only 5'h04 delivered. With FIFO full, a push coincident with key_req -> no ovf, count stays 4.

Source files
------------

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - key codes, RX state encoding and ASCII-to-key map for the SPART key receiver
package spart_pkg;

  localparam logic [4:0] KEY_UP    = 5'h01;
  localparam logic [4:0] KEY_DOWN  = 5'h02;
  localparam logic [4:0] KEY_LEFT  = 5'h04;
  localparam logic [4:0] KEY_RIGHT = 5'h08;
  localparam logic [4:0] KEY_FIRE  = 5'h10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // Returns 5'h00 for any byte that is not a recognised control character.
  function automatic logic [4:0] ascii_to_key(input logic [7:0] c);
    logic [4:0] k;
    case (c)
      8'h57, 8'h77: k = KEY_UP;
      8'h53, 8'h73: k = KEY_DOWN;
      8'h41, 8'h61: k = KEY_LEFT;
      8'h44, 8'h64: k = KEY_RIGHT;
      8'h20:        k = KEY_FIRE;
      default:      k = 5'h00;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/spart_uart_rx.sv
// rtl/spart_uart_rx.sv - 8N1 receiver: rx synchroniser, 16x oversample tick and frame FSM
module spart_uart_rx
  import spart_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic          sync1, sync2, rx_prev;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  rx_state_t     state, next_state;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          fall, os_done, sample_now;
  logic          valid_d, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign fall = rx_prev & ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

  // Start bit is checked at its middle (8 ticks), every later bit a full period on.
  assign os_done    = (state == START) ? (os_cnt == 4'd7) : (os_cnt == 4'd15);
  assign sample_now = tick & os_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fall) next_state = START;
      START: if (sample_now) next_state = sync2 ? IDLE : DATA;
      DATA:  if (sample_now && bit_cnt == 3'd7) next_state = STOP;
      STOP:  if (sample_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (state == IDLE) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (tick) begin
      os_cnt <= os_done ? 4'd0 : os_cnt + 4'd1;
      if (state == DATA && os_done) begin
        shift   <= {sync2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (state == STOP && sample_now) begin
      valid_d = sync2;
      ferr_d  = ~sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_data    <= '0;
    end else begin
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
      if (valid_d) rx_data <= shift;
    end
  end

endmodule

// File: rtl/spart_key_rx.sv
// rtl/spart_key_rx.sv - maps received bytes to one-hot key codes, buffers them and answers CPU polls
module spart_key_rx
  import spart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       key_req,
  output logic       SPART_we,
  output logic [4:0] SPART_keys,
  output logic       frame_err,
  output logic       ovf,
  output logic       fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [4:0]  key;
  logic        push, pop, push_ok, empty, full;
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic [4:0]  mem [FIFO_DEPTH];

  spart_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (rx_valid),
    .rx_data    (rx_data),
    .frame_err  (frame_err)
  );

  assign key   = ascii_to_key(rx_data);
  assign push  = rx_valid && (key != 5'h00);
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot the same cycle, so a push into a full FIFO survives when polled.
  assign pop     = key_req && !empty;
  assign push_ok = push && (!full || pop);
  assign wptr_n  = wptr + (AW+1)'(push_ok);
  assign rptr_n  = rptr + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      SPART_we   <= 1'b0;
      SPART_keys <= 5'h00;
      ovf        <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      SPART_we   <= pop;
      SPART_keys <= pop ? mem[rptr[AW-1:0]] : 5'h00;
      ovf        <= push && full && !pop;
      fifo_empty <= (wptr_n == rptr_n);
    end
  end

endmodule

// File: tb/tb_spart_key_rx.sv
// tb/tb_spart_key_rx.sv - scoreboard bench for spart_key_rx driven by directed serial frames and polls
module tb_spart_key_rx;

  localparam int BAUD_DIV   = 27;
  localparam int FIFO_DEPTH = 4;
  localparam int BITP       = 16 * BAUD_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       key_req = 1'b0;
  logic       SPART_we;
  logic [4:0] SPART_keys;
  logic       frame_err;
  logic       ovf;
  logic       fifo_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int ferr_cnt = 0;
  int byte_cnt = 0;
  logic [5:0] exp_q[$];
  logic       req_q = 1'b0;

  spart_key_rx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .key_req    (key_req),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .frame_err  (frame_err),
    .ovf        (ovf),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_q <= key_req;

  // Monitor: every poll owes exactly one response one clock later.
  always @(negedge clk) begin
    logic [5:0] e;
    if (ovf) ovf_cnt++;
    if (frame_err) ferr_cnt++;
    if (dut.rx_valid) byte_cnt++;
    if (req_q) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL poll_response: got we=%0b keys=%h but no request pending", SPART_we, SPART_keys);
      end else begin
        e = exp_q.pop_front();
        if ({SPART_we, SPART_keys} !== e) begin
          n_fail++;
          $display("FAIL poll_response: got we=%0b keys=%h expected we=%0b keys=%h",
                   SPART_we, SPART_keys, e[5], e[4:0]);
        end
      end
    end else if (SPART_we !== 1'b0 || SPART_keys !== 5'h00) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_outputs: got we=%0b keys=%h expected we=0 keys=00", SPART_we, SPART_keys);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv);
    rx = 1'b0;
    idle(BITP);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BITP);
    end
    rx = stopv;
    idle(BITP);
    rx = 1'b1;
    idle(8);
  endtask

  task automatic poll(input logic [5:0] e);
    exp_q.push_back(e);
    key_req = 1'b1;
    @(negedge clk);
    key_req = 1'b0;
  endtask

  initial begin
    int k;
    int base;
    logic [7:0] w;
    #1 rst = 1'b1;
    idle(3);
    check("reset_we", int'(SPART_we), 0);
    check("reset_keys", int'(SPART_keys), 0);
    check("reset_empty", int'(fifo_empty), 1);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    idle(5);

    send_byte(8'h77, 1'b1);
    check("w_not_empty", int'(fifo_empty), 0);
    poll(6'h21);
    check("w_empty_after", int'(fifo_empty), 1);

    send_byte(8'h44, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h20, 1'b1);
    poll(6'h28);
    poll(6'h30);
    poll(6'h00);
    idle(2);

    base = ovf_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h73, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h64, 1'b1);
    check("full_no_ovf_yet", ovf_cnt - base, 0);
    send_byte(8'h20, 1'b1);
    check("ovf_on_fifth", ovf_cnt - base, 1);

    k = 0;
    fork
      send_byte(8'h77, 1'b1);
      begin
        while (!dut.rx_valid && k < 20 * BITP) begin
          @(negedge clk);
          k++;
        end
        check("coincide_wait_timeout", int'(k < 20 * BITP), 1);
        poll(6'h21);
      end
    join
    check("coincide_no_ovf", ovf_cnt - base, 1);
    poll(6'h22);
    poll(6'h24);
    poll(6'h28);
    poll(6'h21);
    poll(6'h00);
    check("drained_empty", int'(fifo_empty), 1);

    base = ferr_cnt;
    send_byte(8'h61, 1'b0);
    check("frame_err_once", ferr_cnt - base, 1);
    check("frame_err_no_push", int'(fifo_empty), 1);
    send_byte(8'h73, 1'b1);
    poll(6'h22);

    base = byte_cnt;
    k = ferr_cnt;
    rx = 1'b0;
    idle(4 * BAUD_DIV);
    rx = 1'b1;
    idle(10 * BITP);
    check("glitch_no_byte", byte_cnt - base, 0);
    check("glitch_no_err", ferr_cnt - k, 0);
    check("glitch_empty", int'(fifo_empty), 1);

    w = 8'h77;
    rx = 1'b0;
    idle(BITP);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      idle(BITP);
    end
    rx = w[4];
    idle(BITP / 2);
    rst = 1'b1;
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(BITP);
    check("rst_midframe_empty", int'(fifo_empty), 1);
    check("rst_midframe_no_byte", byte_cnt - base, 0);
    send_byte(8'h61, 1'b1);
    poll(6'h24);
    poll(6'h00);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
